// File: rtl/ysyx_23060096_ifu.sv
// Instruction fetch unit: owns the fetch PC, issues single outstanding word reads
// and hands each fetched instruction downstream over a valid/ready handshake.
module ysyx_23060096_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_t;

    state_t state;
    logic   drop;
    logic   misaligned;

    assign misaligned     = pc[1:0] != 2'b00;
    assign imem_req_valid = (state == REQ) && !redirect_valid && !misaligned;
    assign imem_req_addr  = pc;
    assign inst_valid     = (state == HOLD) && !redirect_valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            drop       <= 1'b0;
            pc         <= RESET_PC;
            inst       <= NOP_INST;
            inst_pc    <= RESET_PC;
            inst_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_valid) pc <= redirect_pc;
                    state <= REQ;
                end
                REQ: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end else if (misaligned) begin
                        // Misaligned target never reaches memory; present a faulting NOP instead.
                        inst       <= NOP_INST;
                        inst_pc    <= pc;
                        inst_fault <= 1'b1;
                        state      <= HOLD;
                    end else if (imem_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        if (redirect_valid) begin
                            pc    <= redirect_pc;
                            drop  <= 1'b0;
                            state <= REQ;
                        end else if (drop) begin
                            drop  <= 1'b0;
                            state <= REQ;
                        end else begin
                            inst       <= imem_resp_err ? NOP_INST : imem_resp_data;
                            inst_pc    <= pc;
                            inst_fault <= imem_resp_err;
                            state      <= HOLD;
                        end
                    end else if (redirect_valid) begin
                        // Response still owed by memory; remember to discard it.
                        pc   <= redirect_pc;
                        drop <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        pc    <= redirect_pc;
                        state <= REQ;
                    end else if (inst_ready) begin
                        pc    <= pc + 32'd4;
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060096_ifu.sv
// Randomized scoreboard bench for the fetch unit: a model of the architectural
// fetch stream predicts every delivered instruction and every memory request.
module tb_ysyx_23060096_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk;
    logic        rstn;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pc;

    ysyx_23060096_ifu #(
        .RESET_PC(RESET_PC),
        .NOP_INST(NOP_INST)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .imem_resp_err  (imem_resp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] nxt;
    int unsigned n_cmp;
    int unsigned n_bad;
    int unsigned delivered;
    int          cyc;
    int          rel_cyc;
    int          prev_fire;
    bit          first_fire;
    bit          directed;
    bit          mem_pend;
    logic [31:0] mem_addr;
    int          mem_lat;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h1357};
    endfunction

    function automatic logic err_of(input logic [31:0] a);
        return a[2] & a[5] & a[7];
    endfunction

    // What the downstream stage must see for a fetch of address a.
    function automatic exp_t expect_at(input logic [31:0] a);
        exp_t e;
        e.pc = a;
        if (a[1:0] != 2'b00) begin
            e.data  = NOP_INST;
            e.fault = 1'b1;
        end else begin
            e.fault = err_of(a);
            e.data  = e.fault ? NOP_INST : data_of(a);
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_set(input logic [31:0] a);
        nxt = a;
        exp_q.delete();
        exp_q.push_back(expect_at(a));
    endtask

    task automatic check_reset_outputs();
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_pc", pc, RESET_PC);
        check("rst_inst", inst, NOP_INST);
        check("rst_inst_pc", inst_pc, RESET_PC);
        check("rst_inst_fault", 32'(inst_fault), 32'd0);
    endtask

    function automatic logic [31:0] pick_target();
        int unsigned r;
        r = $urandom_range(0, 15);
        if (r < 10) return RESET_PC + 32'($urandom_range(0, 63) << 2);
        if (r < 12) return RESET_PC + 32'($urandom_range(0, 63) << 2) + 32'($urandom_range(1, 3));
        if (r < 14) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) << 2);
        return 32'($urandom_range(0, 15) << 2);
    endfunction

    // One clock: drive inputs after the falling edge, then predict the next rising edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        check("pc", pc, nxt);
        if (mem_pend && mem_lat == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = data_of(mem_addr);
            imem_resp_err   = err_of(mem_addr);
            mem_pend        = 1'b0;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
            imem_resp_err   = 1'($urandom);
            if (mem_pend) mem_lat--;
        end
        if (directed) begin
            imem_req_ready = 1'b1;
            inst_ready     = 1'b1;
            redirect_valid = 1'b0;
            redirect_pc    = $urandom;
        end else begin
            imem_req_ready = $urandom_range(0, 9) < 7;
            inst_ready     = $urandom_range(0, 9) < 7;
            redirect_valid = $urandom_range(0, 11) == 0;
            redirect_pc    = redirect_valid ? pick_target() : $urandom;
        end
        #1;
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, nxt);
            check("req_aligned", 32'(imem_req_addr[1:0]), 32'd0);
            check("req_during_redirect", 32'(redirect_valid), 32'd0);
            if (first_fire) begin
                check("first_req_cycle", 32'(cyc - rel_cyc), 32'd1);
                first_fire = 1'b0;
            end
            if (directed && prev_fire >= 0) check("req_spacing", 32'(cyc - prev_fire), 32'd3);
            prev_fire = cyc;
            mem_pend  = 1'b1;
            mem_addr  = imem_req_addr;
            mem_lat   = directed ? 0 : int'($urandom_range(0, 3));
        end
        if (redirect_valid) begin
            model_set(redirect_pc);
        end else if (inst_valid && inst_ready && exp_q.size() != 0) begin
            nxt = exp_q[0].pc + 32'd4;
            exp_q.push_back(expect_at(nxt));
        end
    endtask

    task automatic release_reset(input bit stale_resp);
        @(negedge clk);
        cyc++;
        rstn            = 1'b1;
        imem_resp_valid = stale_resp;
        imem_resp_data  = 32'hDEAD_BEEF;
        imem_resp_err   = 1'b0;
        rel_cyc         = cyc;
        first_fire      = 1'b1;
        prev_fire       = -1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT hands an instruction over.
    initial begin : monitor
        exp_t        e;
        bit          pv;
        logic [31:0] p_inst;
        logic [31:0] p_pc;
        logic        p_fault;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rstn) begin
                pv = 1'b0;
            end else begin
                if (pv && inst_valid) begin
                    check("stall_inst", inst, p_inst);
                    check("stall_inst_pc", inst_pc, p_pc);
                    check("stall_fault", 32'(inst_fault), 32'(p_fault));
                end
                if (inst_valid && inst_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_inst: got pc %h with nothing expected", inst_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("inst_pc", inst_pc, e.pc);
                        check("inst", inst, e.data);
                        check("inst_fault", 32'(inst_fault), 32'(e.fault));
                        delivered++;
                    end
                end
                pv      = inst_valid && !inst_ready;
                p_inst  = inst;
                p_pc    = inst_pc;
                p_fault = inst_fault;
            end
        end
    end

    initial begin : driver
        int budget;
        n_cmp = 0; n_bad = 0; delivered = 0; cyc = 0;
        rel_cyc = 0; prev_fire = -1; first_fire = 1'b0; directed = 1'b1;
        mem_pend = 1'b0; mem_addr = '0; mem_lat = 0;
        rstn = 1'b0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0; imem_resp_err = 1'b0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        model_set(RESET_PC);
        repeat (3) @(negedge clk);
        #1 check_reset_outputs();

        release_reset(1'b0);
        repeat (12) step();
        directed = 1'b0;
        repeat (3000) step();

        // Reset while a response is owed, then let the stale response arrive in IDLE.
        budget = 0;
        while (!mem_pend && budget < 200) begin
            step();
            budget++;
        end
        check("wait_reached", 32'(mem_pend), 32'd1);
        @(negedge clk);
        cyc++;
        rstn = 1'b0;
        imem_resp_valid = 1'b0;
        redirect_valid = 1'b0;
        inst_ready = 1'b0;
        mem_pend = 1'b0;
        model_set(RESET_PC);
        #1 check_reset_outputs();
        @(negedge clk);
        cyc++;
        directed = 1'b1;
        release_reset(1'b1);
        repeat (9) step();
        directed = 1'b0;
        repeat (800) step();

        check("enough_delivered", 32'(delivered >= 150), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
